mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the RV64M ops encoded by mul_op_t.
- Sits in execute beside the ALU; the decoder issues one op at a time over a valid/ready handshake.
- Holds the result until writeback accepts it.
- Runs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, then applies a sign fix-up.

Parameters:
- XLEN, 64, operand/result width (from riscv_pkg).
- TAG_W, 5, destination-register tag width carried alongside the op.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  kill in-flight op (branch mispredict or trap).
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- op_i  in  mul_op_t  operation.
- rs1_i  in  XLEN  operand a (multiplicand/dividend).
- rs2_i  in  XLEN  operand b (multiplier/divisor).
- rd_i  in  TAG_W  destination tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.
- rd_o  out  TAG_W  tag of the result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE; in_ready_o = 1; out_valid_o = 0; busy_o = 0; result_o = 0; rd_o = 0; counter = 0.
- Accept: a request is accepted on an edge where in_valid_i && in_ready_o. At that edge the unit latches op, rd, |a|, |b| and the result signs, and clears the 128-bit accumulator.
- in_ready_o = (state == IDLE). The unit is single-outstanding.
- States:
  - IDLE -> MUL when op ∈ {MUL, MULH, MULHSU, MULHU}.
  - IDLE -> DIV when op ∈ {DIV, DIVU, REM, REMU} and no special case applies.
  - IDLE -> DONE for M_NONE or a special case.
  - MUL/DIV -> FIX after exactly 64 iterations (6-bit counter wraps 63 -> 0).
  - FIX -> DONE.
  - DONE -> IDLE when out_ready_i.
- Latency:
  - out_valid_o rises 66 edges after the accept edge (64 iterations + FIX + DONE register).
  - Special cases and M_NONE: out_valid_o rises 1 edge after accept.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are computed at accept. FIX negates the 128-bit product or the quotient/remainder as required.
  - Quotient sign = sa^sb; remainder sign = sa (truncating division).
- Result select:
  - MUL: product[63:0].
  - MULH*: product[127:64].
  - DIV*: quotient.
  - REM*: remainder.
  - M_NONE: 0.
- Special cases, decided at accept:
  - Divide by zero: quotient = all ones; remainder = rs1_i.
  - Signed overflow (rs1 = 0x8000_0000_0000_0000, rs2 = -1, DIV/REM only): quotient = rs1_i; remainder = 0.
- Output hold: in DONE, out_valid_o stays high and result_o/rd_o stay stable until out_ready_i is sampled high.
  - out_ready_i high in the cycle out_valid_o rises completes the handshake that edge; in_ready_o is 1 on the next cycle.
- Flush:
  - flush_i high forces IDLE at the next edge from any state, including DONE, and clears out_valid_o.
  - flush_i has priority over accept: a request presented in the same cycle as flush_i is not accepted.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: multiply ops use a single-cycle combinational 128-bit product, IDLE -> DONE, out_valid_o 1 edge after accept. Divide behaviour is unchanged.
- Undefined: multiply is iterative as above (66 cycles). No wide multiplier is inferred.

Decomposition:
- riscv_pkg additions:
  - mdu_state_t enum {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_FIX, MDU_DONE}.
  - localparam MDU_ITERS = 64.
  - Reuse mul_op_t unchanged.
- Sub-module mdu_div_step (combinational):
  - Inputs: remainder, quotient, divisor.
  - Performs one restoring step: shift {rem, quot} left 1, trial subtract, set quotient LSB.
  - Outputs: next remainder and next quotient.
  - Instantiated once in mdu_seq.

Test Plan:
- MUL rs1 = 3, rs2 = -5 -> result 0xFFFF_FFFF_FFFF_FFF1 at accept+66; MULHU 0xFFFF_FFFF_FFFF_FFFF × same -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU -1 × 2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7/2 -> -3 (0xFFFF_FFFF_FFFF_FFFD); REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 42/0 -> 0xFFFF_FFFF_FFFF_FFFF and REM 42/0 -> 42, out_valid_o 1 edge after accept; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
- Backpressure: out_ready_i low for 10 cycles after out_valid_o -> result_o/rd_o stable, in_ready_o = 0 throughout; out_ready_i high -> in_ready_o = 1 next cycle.
- flush_i at iteration 30 of a DIV -> no out_valid_o; in_ready_o = 1 next cycle; a following MUL 6×7 -> 42 with the correct rd_o.
- rst_n asserted mid-MUL -> all outputs at reset values immediately (asynchronous); with MDU_FAST_MUL_EN defined, MUL 6×7 -> 42 at accept+1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 execute-stage types: M-extension op encoding and the multiply/divide sequencer's state and context.
package riscv_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned MDU_ITERS = 64;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_ITERS);

  typedef enum logic [3:0] {
    M_NONE,
    M_MUL,
    M_MULH,
    M_MULHSU,
    M_MULHU,
    M_DIV,
    M_DIVU,
    M_REM,
    M_REMU
  } mul_op_t;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_FIX,
    MDU_DONE
  } mdu_state_t;

  // Op context latched at accept; neg_q also serves as the product sign for multiplies.
  typedef struct packed {
    mul_op_t op;
    logic    neg_q;
    logic    neg_r;
  } mdu_ctx_t;

  function automatic logic mdu_is_mul(input mul_op_t op);
    return op inside {M_MUL, M_MULH, M_MULHSU, M_MULHU};
  endfunction

  function automatic logic mdu_is_div(input mul_op_t op);
    return op inside {M_DIV, M_DIVU, M_REM, M_REMU};
  endfunction

  // Accumulator holds {hi, lo} = {product high, product low} or {remainder, quotient}.
  function automatic logic [XLEN-1:0] mdu_select(input mul_op_t op, input logic [2*XLEN-1:0] acc);
    logic [XLEN-1:0] res;
    res = '0;
    case (op)
      M_MUL, M_DIV, M_DIVU:                 res = acc[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU,
      M_REM, M_REMU:                        res = acc[2*XLEN-1:XLEN];
      default:                              res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division step: shift {rem, quot} left, trial-subtract the divisor, set the quotient bit.
module mdu_div_step
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[XLEN]) begin
      rem_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = shifted[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer with valid/ready in and out.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle 128-bit product.
module mdu_seq
  import riscv_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  mul_op_t          op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] rd_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o,
  output logic             busy_o
);

  localparam int unsigned AW = 2 * XLEN;

  mdu_state_t           state_q, state_d;
  mdu_ctx_t             ctx_q;
  logic [TAG_W-1:0]     rd_q, rd_out_q;
  logic [XLEN-1:0]      mcand_q, mplr_q;
  logic [AW-1:0]        acc_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic                 in_ready_q, out_valid_q, busy_q;
  logic [XLEN-1:0]      result_q;

  logic                 accept_c, sa_c, sb_c, div_op_c, div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0]      a_mag_c, b_mag_c;
  logic [XLEN:0]        mul_sum_c;
  logic [XLEN-1:0]      div_rem_c, div_quot_c;
  logic [AW-1:0]        fix_c;
  logic                 last_iter_c;

  // Operand signs, magnitudes and divide special cases, all decided at accept
  always_comb begin
    sa_c       = (op_i inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM}) & rs1_i[XLEN-1];
    sb_c       = (op_i inside {M_MUL, M_MULH, M_DIV, M_REM}) & rs2_i[XLEN-1];
    a_mag_c    = sa_c ? -rs1_i : rs1_i;
    b_mag_c    = sb_c ? -rs2_i : rs2_i;
    div_op_c   = mdu_is_div(op_i);
    div_zero_c = div_op_c && (rs2_i == '0);
    div_ovf_c  = (op_i inside {M_DIV, M_REM}) && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special_c  = div_zero_c | div_ovf_c;
    accept_c   = in_valid_i & in_ready_q & ~flush_i;
  end

`ifdef MDU_FAST_MUL_EN
  logic [AW-1:0] fast_prod_c;
  assign fast_prod_c = AW'(a_mag_c) * AW'(b_mag_c);
`endif

  // Shift-add: add multiplicand into the high half when the multiplier LSB is set, then shift right
  assign mul_sum_c   = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, mcand_q & {XLEN{mplr_q[0]}}};
  assign last_iter_c = (cnt_q == MDU_CNT_W'(MDU_ITERS - 1));

  mdu_div_step u_div_step (
    .rem_i  (acc_q[AW-1:XLEN]),
    .quot_i (acc_q[XLEN-1:0]),
    .div_i  (mplr_q),
    .rem_o  (div_rem_c),
    .quot_o (div_quot_c)
  );

  // Sign fix-up: full 128-bit negate for products, independent halves for quotient/remainder
  always_comb begin
    fix_c = acc_q;
    if (mdu_is_mul(ctx_q.op)) begin
      if (ctx_q.neg_q) fix_c = -acc_q;
    end else begin
      fix_c[XLEN-1:0]  = ctx_q.neg_q ? -acc_q[XLEN-1:0]  : acc_q[XLEN-1:0];
      fix_c[AW-1:XLEN] = ctx_q.neg_r ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: begin
        if (in_valid_i) begin
          if (mdu_is_mul(op_i)) begin
`ifdef MDU_FAST_MUL_EN
            state_d = MDU_DONE;
`else
            state_d = MDU_MUL;
`endif
          end else if (div_op_c && !special_c) begin
            state_d = MDU_DIV;
          end else begin
            state_d = MDU_DONE;
          end
        end
      end
      MDU_MUL, MDU_DIV: if (last_iter_c) state_d = MDU_FIX;
      MDU_FIX:          state_d = MDU_DONE;
      MDU_DONE:         if (out_valid_q && out_ready_i) state_d = MDU_IDLE;
      default:          state_d = MDU_IDLE;
    endcase
    if (flush_i) state_d = MDU_IDLE;
  end

  // Datapath: operand capture, one iteration per cycle, fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_q   <= '0;
      rd_q    <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      ctx_q   <= '{op: op_i, neg_q: sa_c ^ sb_c, neg_r: sa_c};
      rd_q    <= rd_i;
      mcand_q <= a_mag_c;
      mplr_q  <= b_mag_c;
      cnt_q   <= '0;
      if (div_zero_c)      acc_q <= {rs1_i, {XLEN{1'b1}}};
      else if (div_ovf_c)  acc_q <= {{XLEN{1'b0}}, rs1_i};
      else if (div_op_c)   acc_q <= {{XLEN{1'b0}}, a_mag_c};
`ifdef MDU_FAST_MUL_EN
      else if (mdu_is_mul(op_i)) acc_q <= (sa_c ^ sb_c) ? -fast_prod_c : fast_prod_c;
`endif
      else                 acc_q <= '0;
    end else begin
      case (state_q)
        MDU_MUL: begin
          acc_q  <= {mul_sum_c, acc_q[XLEN-1:1]};
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + MDU_CNT_W'(1);
        end
        MDU_DIV: begin
          acc_q <= {div_rem_c, div_quot_c};
          cnt_q <= cnt_q + MDU_CNT_W'(1);
        end
        MDU_FIX: acc_q <= fix_c;
        default: ;
      endcase
    end
  end

  // Registered handshake and result; the result register loads on the first DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
    end else begin
      in_ready_q  <= (state_d == MDU_IDLE);
      busy_q      <= (state_d != MDU_IDLE);
      out_valid_q <= (state_q == MDU_DONE) && !(out_valid_q && out_ready_i) && !flush_i;
      if ((state_q == MDU_DONE) && !out_valid_q && !flush_i) begin
        result_q <= mdu_select(ctx_q.op, acc_q);
        rd_out_q <= rd_q;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign rd_o        = rd_out_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed scoreboard bench for mdu_seq.
module tb_mdu_seq;
  import riscv_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 66;
`endif
  localparam int DIV_LAT = 66;
  localparam int SPC_LAT = 1;

  logic            clk, rst_n, flush_i, in_valid_i, in_ready_o;
  mul_op_t         op_i;
  logic [63:0]     rs1_i, rs2_i, result_o;
  logic [4:0]      rd_i, rd_o;
  logic            out_valid_o, out_ready_i, busy_o;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  mdu_seq #(.TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rd_i        (rd_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .rd_o        (rd_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input mul_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp_res, input int lat);
    sb_entry_t e;
    e.res = exp_res;
    e.rd  = rd;
    e.lat = lat;
    sb_q.push_back(e);
    chk("in_ready_idle", 64'(in_ready_o), 64'd1);
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0; op_i = M_NONE; rs1_i = '0; rs2_i = '0; rd_i = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic retire(input string tag, input int n);
    sb_entry_t e;
    e = sb_q.pop_front();
    chk({tag, "_valid"},   64'(out_valid_o), 64'd1);
    chk({tag, "_result"},  result_o,         e.res);
    chk({tag, "_rd"},      64'(rd_o),        64'(e.rd));
    chk({tag, "_latency"}, 64'(n),           64'(e.lat));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, "_ready_after"}, 64'(in_ready_o), 64'd1);
  endtask

  task automatic run(input string tag, input mul_op_t op, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, input logic [63:0] exp_res, input int lat);
    int n;
    issue(op, a, b, rd, exp_res, lat);
    wait_valid(n);
    retire(tag, n);
  endtask

  initial begin
    int n;
    int seen;
    logic [63:0] held_res;
    logic [4:0]  held_rd;
    sb_entry_t   dropped;

    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = M_NONE; rs1_i = '0; rs2_i = '0; rd_i = '0;
    #23;
    chk("rst_in_ready",  64'(in_ready_o),  64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy",      64'(busy_o),      64'd0);
    chk("rst_result",    result_o,         64'd0);
    rst_n = 1'b1;
    tick();

    // Multiply
    run("mul_3x-5",    M_MUL,    64'd3,                   -64'sd5,                 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT);
    run("mulhu_max",   M_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
    run("mulhsu_-1x2", M_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   5'd3, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
    run("mulh_min",    M_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 64'h4000_0000_0000_0000, MUL_LAT);

    // Divide
    run("div_-7/2",    M_DIV,    -64'sd7, 64'd2,  5'd5,  64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    run("rem_-7/2",    M_REM,    -64'sd7, 64'd2,  5'd6,  64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
    run("div_7/-2",    M_DIV,    64'd7,   -64'sd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    run("divu_100/7",  M_DIVU,   64'd100, 64'd7,  5'd8,  64'd14, DIV_LAT);
    run("remu_100/7",  M_REMU,   64'd100, 64'd7,  5'd9,  64'd2,  DIV_LAT);

    // Special cases and no-op
    run("divu_by0",    M_DIVU,   64'd42, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, SPC_LAT);
    run("rem_by0",     M_REM,    64'd42, 64'd0, 5'd11, 64'd42, SPC_LAT);
    run("div_ovf",     M_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'h8000_0000_0000_0000, SPC_LAT);
    run("rem_ovf",     M_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, SPC_LAT);
    run("none",        M_NONE,   64'd5, 64'd6, 5'd14, 64'd0, SPC_LAT);

    // Backpressure: result held for 10 cycles with out_ready low
    issue(M_MUL, 64'd3, -64'sd5, 5'd21, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT);
    wait_valid(n);
    held_res = result_o;
    held_rd  = rd_o;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid",    64'(out_valid_o), 64'd1);
      chk("bp_in_ready", 64'(in_ready_o),  64'd0);
      chk("bp_result",   result_o,         held_res);
      chk("bp_rd",       64'(rd_o),        64'(held_rd));
    end
    retire("bp", n);

    // Flush takes priority over a same-cycle request
    op_i = M_DIVU; rs1_i = 64'd9; rs2_i = 64'd3; rd_i = 5'd15; in_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_prio_ready", 64'(in_ready_o), 64'd1);
    chk("flush_prio_busy",  64'(busy_o),     64'd0);

    // Flush during a divide at iteration 30
    issue(M_DIV, 64'd1000, 64'd3, 5'd16, 64'd333, DIV_LAT);
    repeat (30) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    dropped = sb_q.pop_front();
    chk("flush_in_ready",  64'(in_ready_o),  64'd1);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_busy",      64'(busy_o),      64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid_o) seen = 1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run("mul_after_flush", M_MUL, 64'd6, 64'd7, 5'd17, 64'd42, MUL_LAT);

    // Asynchronous reset during a multiply
    issue(M_MUL, 64'd11, 64'd13, 5'd18, 64'd143, MUL_LAT);
    if (MUL_LAT > 1) repeat (20) tick();
    #3 rst_n = 1'b0;
    #1;
    dropped = sb_q.pop_front();
    chk("arst_in_ready",  64'(in_ready_o),  64'd1);
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_busy",      64'(busy_o),      64'd0);
    chk("arst_result",    result_o,         64'd0);
    chk("arst_rd",        64'(rd_o),        64'd0);
    #2 rst_n = 1'b1;
    tick();
    run("mul_after_rst", M_MUL, 64'd6, 64'd7, 5'd19, 64'd42, MUL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
